// File: rtl/mode_report_tx.sv
// Reports each work-mode change on sel as one ASCII byte over an 8N1 UART line.
// Optional macro MODE_TX_CR_EN appends a contiguous 8'h0D frame after every code frame.
module mode_report_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel,
    output logic       tx,
    output logic       busy
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

`ifdef MODE_TX_CR_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, SUFFIX} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic [1:0]      sel_q;
    logic            pending;
    logic [7:0]      pend_code;
    logic [7:0]      shift;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic            tx_d;
    logic            busy_d;
    logic            change;
    logic            take;
    logic            bit_end;
`ifdef MODE_TX_CR_EN
    logic            sfx_frame;
`endif

    function automatic logic [7:0] encode(input logic [1:0] s);
        case (s)
            2'b00:   encode = 8'd69;
            2'b01:   encode = 8'd70;
            2'b10:   encode = 8'd71;
            default: encode = 8'd68;
        endcase
    endfunction

    assign change  = (sel != sel_q);
    assign take    = (state == IDLE) && pending;
    assign bit_end = (baud_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // tx/busy are computed per state here and registered below, so the line
    // trails the FSM by one cycle and stays glitch-free.
    always_comb begin
        state_next = state;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        case (state)
            IDLE: begin
                if (pending) state_next = START;
            end
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx_d   = shift[0];
                busy_d = 1'b1;
                if (bit_end && bit_cnt == 3'd7) state_next = STOP;
            end
            STOP: begin
                busy_d = 1'b1;
                if (bit_end) begin
`ifdef MODE_TX_CR_EN
                    state_next = sfx_frame ? IDLE : SUFFIX;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef MODE_TX_CR_EN
            SUFFIX: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
                if (bit_end) state_next = DATA;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            tx   <= tx_d;
            busy <= busy_d;
        end
    end

    // A change on the same edge as the hand-off wins, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 2'b00;
            pending   <= 1'b0;
            pend_code <= 8'h00;
        end else begin
            sel_q <= sel;
            if (change) begin
                pending   <= 1'b1;
                pend_code <= encode(sel);
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else begin
            if (state == IDLE || state_next != state || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 8'h00;
        end else if (take) begin
            shift <= pend_code;
        end else if (state == DATA && bit_end) begin
            shift <= {1'b0, shift[7:1]};
`ifdef MODE_TX_CR_EN
        end else if (state == STOP && bit_end && !sfx_frame) begin
            shift <= 8'h0D;
`endif
        end
    end

`ifdef MODE_TX_CR_EN
    // Distinguishes the code frame's stop bit from the suffix frame's stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfx_frame <= 1'b0;
        end else if (state == STOP && bit_end) begin
            sfx_frame <= !sfx_frame;
        end
    end
`endif

endmodule

// File: tb/tb_mode_report_tx.sv
// Directed bench for mode_report_tx at CLKS_PER_BIT = 10; honours MODE_TX_CR_EN.
module tb_mode_report_tx;

    localparam int CPB = 10;
`ifdef MODE_TX_CR_EN
    localparam int FL = 20 * CPB;
`else
    localparam int FL = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic       tx;
    logic       busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   cap_len  = 0;
    logic s_tx [0:399];

    mode_report_tx #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag, input int max);
        int k = 0;
        while (busy !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_start"}, 32'(busy), 32'd1);
    endtask

    // Records tx once per cycle for as long as busy is high.
    task automatic capture();
        cap_len = 0;
        while (busy === 1'b1 && cap_len < 400) begin
            s_tx[cap_len] = tx;
            cap_len++;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] decode(input int off);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = s_tx[off + 15 + 10 * k];
        return d;
    endfunction

    function automatic logic framing(input int off);
        return (s_tx[off + 5] === 1'b0) && (s_tx[off + 95] === 1'b1);
    endfunction

    task automatic check_report(input string tag, input logic [7:0] code);
        check({tag, "_busy_len"}, 32'(cap_len), 32'(FL));
        check({tag, "_byte"}, 32'(decode(0)), 32'(code));
        check({tag, "_framing"}, 32'(framing(0)), 32'd1);
`ifdef MODE_TX_CR_EN
        check({tag, "_suffix"}, 32'(decode(100)), 32'h0D);
        check({tag, "_suffix_framing"}, 32'(framing(100)), 32'd1);
`endif
    endtask

    task automatic quiet(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [1:0] seq_sel  [4];
        logic [7:0] seq_code [4];
        int start;
        seq_sel  = '{2'b01, 2'b10, 2'b11, 2'b00};
        seq_code = '{8'h46, 8'h47, 8'h44, 8'h45};

        // reset and quiet idle with sel = 00
        rst_n = 1'b1;
        sel   = 2'b00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        quiet("idle_after_reset", 500);

        // 00 -> 01: two-edge latency then 0x46
        sel = 2'b01;
        @(negedge clk);
        check("lat_edge0_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_edge1_tx", 32'(tx), 32'd1);
        @(negedge clk);
        check("lat_edge2_tx", 32'(tx), 32'd0);
        check("lat_edge2_busy", 32'(busy), 32'd1);
        capture();
        check_report("f46", 8'h46);
        check("f46_end_tx", 32'(tx), 32'd1);

        // 01 -> 00: 0x45
        sel = 2'b00;
        wait_busy("f45", 10);
        capture();
        check_report("f45", 8'h45);
        quiet("f45_quiet", 20);

        // changes during a frame collapse into one follow-up frame
        sel = 2'b01;
        wait_busy("inflight", 10);
        fork
            capture();
            begin
                repeat (30) @(negedge clk);
                sel = 2'b10;
                repeat (20) @(negedge clk);
                sel = 2'b11;
            end
        join
        check_report("inflight_f46", 8'h46);
        check("gap_tx", 32'(tx), 32'd1);
        check("gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("gap_one_cycle", 32'(busy), 32'd1);
        capture();
        check_report("followup_f44", 8'h44);
        quiet("single_followup", 300);

        // reset mid-frame aborts it; sel = 00 afterwards gives no frame
        sel = 2'b00;
        wait_busy("abort", 10);
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet("no_resume", 300);

        // mode sequence, reports spaced at least 150 cycles apart
        for (int i = 0; i < 4; i++) begin
            start = cyc;
            sel = seq_sel[i];
            wait_busy("seq", 10);
            capture();
            check_report("seq", seq_code[i]);
            while (cyc - start < 150) @(negedge clk);
        end

        // 00 -> 10: 0x47 (followed by 0x0D when the suffix is enabled)
        quiet("pre_f47", 20);
        sel = 2'b10;
        wait_busy("f47", 10);
        capture();
        check_report("f47", 8'h47);
        quiet("post_f47", 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
